// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: three-digit multiplexed seven-segment driver for a packed BCD
// counter. The count is captured once per scan frame so a digit never tears,
// one digit is shown per scan slot, and a sticky overflow flag lights the
// units decimal point.
// Optional feature: define BCD_LZ_BLANK_EN to blank leading zeros on the
// hundreds and tens digits.
module bcd_seg_scan #(
    parameter int unsigned SCAN_DIV = 50000  // clocks per digit slot, 2..65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] q_bcd,
    input  logic        count_in,
    input  logic        hold,
    input  logic        ovf_clr,
    output logic [7:0]  seg,
    output logic [2:0]  sel,
    output logic        ovf
);

    typedef enum logic [1:0] {
        DIG_UNITS    = 2'd0,
        DIG_TENS     = 2'd1,
        DIG_HUNDREDS = 2'd2
    } digit_t;

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    logic [15:0] prescaler;
    logic        tick;
    digit_t      idx;
    logic [11:0] snapshot;
    logic        load_pending;
    logic        frame_load;
    logic [7:0]  seg_next;
    logic [2:0]  sel_next;
    logic [3:0]  nibble;
    logic        blank;

    // Active-low {g,f,e,d,c,b,a} pattern with dp off; non-decimal codes show a dash.
    function automatic logic [7:0] decode(input logic [3:0] n);
        case (n)
            4'd0:    decode = 8'hC0;
            4'd1:    decode = 8'hF9;
            4'd2:    decode = 8'hA4;
            4'd3:    decode = 8'hB0;
            4'd4:    decode = 8'h99;
            4'd5:    decode = 8'h92;
            4'd6:    decode = 8'h82;
            4'd7:    decode = 8'hF8;
            4'd8:    decode = 8'h80;
            4'd9:    decode = 8'h90;
            default: decode = 8'hBF;
        endcase
    endfunction

    assign tick       = (prescaler == DIV_LAST);
    assign frame_load = tick && (idx == DIG_HUNDREDS) && !hold;

    // Slot prescaler and scan index; both stay parked while the initial load is pending
    // so the first units slot is a full SCAN_DIV cycles long.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            idx       <= DIG_UNITS;
        end else if (!load_pending) begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values and simulation matches the synthesized flops.
            if (tick) begin
                prescaler <= '0;
                case (idx)
                    DIG_UNITS: idx <= DIG_TENS;
                    DIG_TENS:  idx <= DIG_HUNDREDS;
                    default:   idx <= DIG_UNITS;
                endcase
            end else begin
                prescaler <= prescaler + 16'd1;
            end
        end
    end

    // Snapshot: forced load right after reset, then once per frame unless held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snapshot     <= '0;
            load_pending <= 1'b1;
        end else begin
            load_pending <= 1'b0;
            if (load_pending || frame_load) begin
                snapshot <= q_bcd;
            end
        end
    end

    // Sticky overflow: a carry in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (count_in) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    // Select the current digit, apply blanking and the overflow decimal point.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        nibble   = snapshot[3:0];
        blank    = 1'b0;
        sel_next = 3'b111;
        seg_next = 8'hFF;
        case (idx)
            DIG_UNITS: begin
                nibble   = snapshot[3:0];
                sel_next = 3'b110;
            end
            DIG_TENS: begin
                nibble   = snapshot[7:4];
                sel_next = 3'b101;
`ifdef BCD_LZ_BLANK_EN
                blank    = (snapshot[11:8] == 4'd0) && (snapshot[7:4] == 4'd0);
`endif
            end
            DIG_HUNDREDS: begin
                nibble   = snapshot[11:8];
                sel_next = 3'b011;
`ifdef BCD_LZ_BLANK_EN
                blank    = (snapshot[11:8] == 4'd0);
`endif
            end
            default: begin
                nibble   = 4'd0;
                sel_next = 3'b111;
                blank    = 1'b1;
            end
        endcase
        if (!blank) begin
            seg_next = decode(nibble);
        end
        if (idx == DIG_UNITS && ovf) begin
            seg_next[7] = 1'b0;
        end
    end

    // seg and sel share one register stage so they can never be skewed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= 8'hFF;
            sel <= 3'b111;
        end else if (load_pending) begin
            seg <= 8'hFF;
            sel <= 3'b111;
        end else begin
            seg <= seg_next;
            sel <= sel_next;
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan with a 4-cycle scan slot.
// Expectations follow BCD_LZ_BLANK_EN when the same macro is defined for the bench.
`timescale 1ns/1ps
module tb_bcd_seg_scan;

    localparam int unsigned SCAN_DIV = 4;

    logic        clk;
    logic        rst_n;
    logic [11:0] q_bcd;
    logic        count_in;
    logic        hold;
    logic        ovf_clr;
    logic [7:0]  seg;
    logic [2:0]  sel;
    logic        ovf;

    int checks;
    int failures;

    bcd_seg_scan #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .q_bcd    (q_bcd),
        .count_in (count_in),
        .hold     (hold),
        .ovf_clr  (ovf_clr),
        .seg      (seg),
        .sel      (sel),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Digit enables in scan order: units, tens, hundreds.
    logic [2:0] slot_sel [3];
    initial begin
        slot_sel[0] = 3'b110;
        slot_sel[1] = 3'b101;
        slot_sel[2] = 3'b011;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reset, release, and let the forced snapshot load happen; the next edge
    // starts the first units slot.
    task automatic reset_dut(input logic [11:0] value);
        rst_n    = 1'b0;
        q_bcd    = value;
        count_in = 1'b0;
        ovf_clr  = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        q_bcd    = 12'h705;
        count_in = 1'b0;
        hold     = 1'b0;
        ovf_clr  = 1'b0;
        step(3);
        checks++;
        if (seg !== 8'hFF || sel !== 3'b111 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: seg=%h sel=%b ovf=%b expected seg=ff sel=111 ovf=0", seg, sel, ovf);
        end
        rst_n = 1'b1;
        step(2);
        checks++;
        if (sel !== 3'b110 || seg !== 8'h92) begin
            failures++;
            $display("FAIL reset_release: sel=%b seg=%h expected sel=110 seg=92", sel, seg);
        end
    endtask

    task automatic test_scan;
        logic [7:0] exp_seg [3];
        exp_seg[0] = 8'h92;
        exp_seg[1] = 8'hC0;
        exp_seg[2] = 8'hF8;
        reset_dut(12'h705);
        for (int f = 0; f < 2; f++)
            for (int d = 0; d < 3; d++)
                for (int c = 0; c < 4; c++) begin
                    step(1);
                    checks++;
                    if (sel !== slot_sel[d] || seg !== exp_seg[d]) begin
                        failures++;
                        $display("FAIL scan_705 f%0d d%0d c%0d: sel=%b seg=%h expected sel=%b seg=%h",
                                 f, d, c, sel, seg, slot_sel[d], exp_seg[d]);
                    end
                end
    endtask

    task automatic test_leading_zero;
        logic [7:0] exp_seg [3];
        exp_seg[0] = 8'h92;
`ifdef BCD_LZ_BLANK_EN
        exp_seg[1] = 8'hFF;
        exp_seg[2] = 8'hFF;
`else
        exp_seg[1] = 8'hC0;
        exp_seg[2] = 8'hC0;
`endif
        reset_dut(12'h005);
        for (int d = 0; d < 3; d++)
            for (int c = 0; c < 4; c++) begin
                step(1);
                checks++;
                if (sel !== slot_sel[d] || seg !== exp_seg[d]) begin
                    failures++;
                    $display("FAIL lz_005 d%0d c%0d: sel=%b seg=%h expected sel=%b seg=%h",
                             d, c, sel, seg, slot_sel[d], exp_seg[d]);
                end
            end
    endtask

    task automatic test_invalid;
        logic [7:0] exp_seg [3];
        exp_seg[0] = 8'hB0;
        exp_seg[1] = 8'hBF;
`ifdef BCD_LZ_BLANK_EN
        exp_seg[2] = 8'hFF;
`else
        exp_seg[2] = 8'hC0;
`endif
        reset_dut(12'h0A3);
        for (int d = 0; d < 3; d++)
            for (int c = 0; c < 4; c++) begin
                step(1);
                checks++;
                if (sel !== slot_sel[d] || seg !== exp_seg[d]) begin
                    failures++;
                    $display("FAIL invalid_0a3 d%0d c%0d: sel=%b seg=%h expected sel=%b seg=%h",
                             d, c, sel, seg, slot_sel[d], exp_seg[d]);
                end
            end
    endtask

    task automatic test_overflow;
        reset_dut(12'h705);
        step(1);  // units slot, cycle 0
        checks++;
        if (ovf !== 1'b0 || seg !== 8'h92) begin
            failures++;
            $display("FAIL ovf_idle: ovf=%b seg=%h expected ovf=0 seg=92", ovf, seg);
        end
        count_in = 1'b1;
        step(1);  // cycle 1: flag rises, seg still from the old flag
        count_in = 1'b0;
        checks++;
        if (ovf !== 1'b1 || seg !== 8'h92) begin
            failures++;
            $display("FAIL ovf_set: ovf=%b seg=%h expected ovf=1 seg=92", ovf, seg);
        end
        step(1);  // cycle 2: dp now lit
        checks++;
        if (seg !== 8'h12 || sel !== 3'b110) begin
            failures++;
            $display("FAIL ovf_dp: seg=%h sel=%b expected seg=12 sel=110", seg, sel);
        end
        count_in = 1'b1;
        ovf_clr  = 1'b1;
        step(1);  // cycle 3: set beats clear
        count_in = 1'b0;
        checks++;
        if (ovf !== 1'b1 || seg !== 8'h12) begin
            failures++;
            $display("FAIL ovf_set_wins: ovf=%b seg=%h expected ovf=1 seg=12", ovf, seg);
        end
        step(1);  // tens cycle 0: clear takes effect
        ovf_clr = 1'b0;
        checks++;
        if (ovf !== 1'b0 || seg !== 8'hC0 || sel !== 3'b101) begin
            failures++;
            $display("FAIL ovf_clear: ovf=%b seg=%h sel=%b expected ovf=0 seg=c0 sel=101", ovf, seg, sel);
        end
        step(8);  // back to units cycle 0
        checks++;
        if (sel !== 3'b110 || seg !== 8'h92) begin
            failures++;
            $display("FAIL ovf_dp_off: sel=%b seg=%h expected sel=110 seg=92", sel, seg);
        end
    endtask

    task automatic test_hold;
        logic [7:0] old_seg [3];
        logic [7:0] new_seg [3];
        old_seg[0] = 8'h92; old_seg[1] = 8'hC0; old_seg[2] = 8'hF8;
        new_seg[0] = 8'hB0; new_seg[1] = 8'hA4; new_seg[2] = 8'hF9;
        // Hold is already high through reset: the first load must still happen.
        hold = 1'b1;
        reset_dut(12'h705);
        q_bcd = 12'h123;
        for (int f = 0; f < 2; f++)
            for (int d = 0; d < 3; d++)
                for (int c = 0; c < 4; c++) begin
                    step(1);
                    checks++;
                    if (sel !== slot_sel[d] || seg !== old_seg[d]) begin
                        failures++;
                        $display("FAIL hold_frozen f%0d d%0d c%0d: sel=%b seg=%h expected sel=%b seg=%h",
                                 f, d, c, sel, seg, slot_sel[d], old_seg[d]);
                    end
                end
        hold = 1'b0;
        // This frame still shows 705; its final hundreds tick captures 123.
        for (int f = 0; f < 2; f++)
            for (int d = 0; d < 3; d++)
                for (int c = 0; c < 4; c++) begin
                    step(1);
                    checks++;
                    if (sel !== slot_sel[d] || seg !== (f == 0 ? old_seg[d] : new_seg[d])) begin
                        failures++;
                        $display("FAIL hold_release f%0d d%0d c%0d: sel=%b seg=%h expected sel=%b seg=%h",
                                 f, d, c, sel, seg, slot_sel[d], (f == 0 ? old_seg[d] : new_seg[d]));
                    end
                end
    endtask

    task automatic test_reset_midframe;
        reset_dut(12'h705);
        count_in = 1'b1;
        step(1);
        count_in = 1'b0;
        step(5);  // now inside the tens slot with ovf set
        rst_n = 1'b0;
        #1;
        checks++;
        if (seg !== 8'hFF || sel !== 3'b111 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: seg=%h sel=%b ovf=%b expected seg=ff sel=111 ovf=0", seg, sel, ovf);
        end
        step(1);
        rst_n = 1'b1;
        step(2);
        checks++;
        if (sel !== 3'b110 || seg !== 8'h92) begin
            failures++;
            $display("FAIL reset_restart: sel=%b seg=%h expected sel=110 seg=92", sel, seg);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_scan();
        test_leading_zero();
        test_invalid();
        test_overflow();
        test_hold();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
